// File: rtl/tail_light_pkg.sv
// tail_light_pkg: shared state, mode codes and fill-pattern helper for the tail-light sequencer
package tail_light_pkg;
  localparam int LAMPS_MAX = 8;
  typedef enum logic [1:0] {IDLE, HAZ, TURN, LANE} state_t;
  localparam logic [2:0] MODE_IDLE   = 3'd0;
  localparam logic [2:0] MODE_HAZ    = 3'd1;
  localparam logic [2:0] MODE_TURN_L = 3'd2;
  localparam logic [2:0] MODE_TURN_R = 3'd3;
  localparam logic [2:0] MODE_LANE_L = 3'd4;
  localparam logic [2:0] MODE_LANE_R = 3'd5;
  function automatic logic [LAMPS_MAX-1:0] fill_pattern(input logic [3:0] step);
    return LAMPS_MAX'((9'd1 << step) - 9'd1);
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every TICK_DIV clocks, restartable by clr
module tick_prescaler #(
  parameter int TICK_DIV = 5000000
) (
  input  logic ADC_CLK_10,
  input  logic RST,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] r_cnt;
  assign tick = r_cnt == W'(TICK_DIV - 1);
  // count 0..TICK_DIV-1, restarting from zero when the owner changes activity
  always_ff @(posedge ADC_CLK_10)
    r_cnt <= (RST || clr || tick) ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/tail_light_seq.sv
// tail_light_seq: turn/hazard/brake/lane-change sequencer for two lamp banks
module tail_light_seq
  import tail_light_pkg::*;
#(
  parameter int LAMPS     = 3,
  parameter int TICK_DIV  = 5000000,
  parameter int LC_CYCLES = 3
) (
  input  logic             ADC_CLK_10,
  input  logic             RST,
  input  logic             hazard,
  input  logic             turn_en,
  input  logic             turn_dir,
  input  logic             brake,
  input  logic             lane_req,
  output logic [LAMPS-1:0] led_left,
  output logic [LAMPS-1:0] led_right,
  output logic [2:0]       mode_code,
  output logic             brake_active
);
  localparam logic [LAMPS-1:0] ONES = {LAMPS{1'b1}};
  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_step;
  logic [3:0]       r_lc_count;
  logic             r_phase;
  logic             r_dir;
  logic             r_lane_dir;
  logic             r_brake_q;
  logic             w_tick;
  logic             w_clr;
  logic             w_wrap;
  logic             w_lane_done;
  logic             w_sdir;
  logic [LAMPS-1:0] w_sig;
  logic [LAMPS-1:0] w_bank;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .ADC_CLK_10(ADC_CLK_10),
    .RST       (RST),
    .clr       (w_clr),
    .tick      (w_tick)
  );
  // next state by priority hazard > turn > lane in progress/request > idle; clear timing on any activity change
  always_comb begin
    w_wrap      = w_tick && r_step == 4'(LAMPS);
    w_lane_done = r_state == LANE && w_wrap && r_lc_count == 4'(LC_CYCLES - 1);
    w_next      = hazard ? HAZ : turn_en ? TURN : r_state == LANE ? (w_lane_done ? IDLE : LANE) : lane_req ? LANE : IDLE;
    w_clr       = w_next != r_state || (r_state == TURN && turn_dir != r_dir);
  end
  // sequencer state: fill step, hazard phase, lane sweep count and sampled inputs
  always_ff @(posedge ADC_CLK_10)
    if (RST) begin
      r_state    <= IDLE;
      r_step     <= '0;
      r_lc_count <= '0;
      r_phase    <= 1'b1;
      r_dir      <= 1'b0;
      r_lane_dir <= 1'b0;
      r_brake_q  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_step     <= w_clr ? '0 : (w_tick && (r_state == TURN || r_state == LANE)) ? (w_wrap ? '0 : r_step + 4'd1) : r_step;
      r_lc_count <= (r_state != LANE || w_next != LANE) ? '0 : w_wrap ? r_lc_count + 4'd1 : r_lc_count;
      r_phase    <= w_clr ? 1'b1 : w_tick ? ~r_phase : r_phase;
      r_dir      <= turn_dir;
      r_lane_dir <= (r_state != LANE && w_next == LANE) ? turn_dir : r_lane_dir;
      r_brake_q  <= brake;
    end
  // Moore decode of lamp banks and mode code from registered state
  always_comb begin
    w_sig     = LAMPS'(fill_pattern(r_step));
    w_bank    = r_brake_q ? ONES : '0;
    w_sdir    = r_state == LANE ? r_lane_dir : r_dir;
    led_left  = r_state == IDLE ? w_bank : r_state == HAZ ? (r_phase ? ONES : '0) : w_sdir ? w_sig : w_bank;
    led_right = r_state == IDLE ? w_bank : r_state == HAZ ? (r_phase ? ONES : '0) : w_sdir ? w_bank : w_sig;
    mode_code = r_state == IDLE ? MODE_IDLE : r_state == HAZ ? MODE_HAZ :
                r_state == TURN ? (w_sdir ? MODE_TURN_L : MODE_TURN_R) : (w_sdir ? MODE_LANE_L : MODE_LANE_R);
  end
  assign brake_active = r_brake_q;
endmodule

// File: tb/tb_tail_light_seq.sv
// tb_tail_light_seq: scenario and randomized checks of tail_light_seq against an elapsed-time reference model
module tb_tail_light_seq;
  localparam int L  = 3;
  localparam int TD = 4;
  localparam int LC = 2;
  localparam int LANE_LEN = LC * (L + 1) * TD;
  logic clk = 0, rst = 0, hazard = 0, turn_en = 0, turn_dir = 0, brake = 0, lane_req = 0;
  logic [L-1:0] led_left, led_right;
  logic [2:0] mode_code;
  logic brake_active;
  logic [9:0] dut_v;
  int vectors = 0, miscompares = 0;
  int m_mode = 0, m_t = 0;
  logic m_dir = 0, m_brake = 0;
  tail_light_seq #(.LAMPS(L), .TICK_DIV(TD), .LC_CYCLES(LC)) dut (
    .ADC_CLK_10  (clk),
    .RST         (rst),
    .hazard      (hazard),
    .turn_en     (turn_en),
    .turn_dir    (turn_dir),
    .brake       (brake),
    .lane_req    (lane_req),
    .led_left    (led_left),
    .led_right   (led_right),
    .mode_code   (mode_code),
    .brake_active(brake_active)
  );
  always #5 clk = ~clk;
  assign dut_v = {mode_code, led_left, led_right, brake_active};
  task automatic model_step();
    int nm;
    if (rst) begin
      m_mode = 0; m_t = 0; m_brake = 0; m_dir = 0;
    end else begin
      nm = hazard ? 1 : turn_en ? 2 : m_mode == 3 ? (m_t + 1 == LANE_LEN ? 0 : 3) : lane_req ? 3 : 0;
      if (nm != m_mode || (nm == 2 && turn_dir != m_dir)) m_t = 0; else m_t++;
      if (nm == 2 || (nm == 3 && m_mode != 3)) m_dir = turn_dir;
      m_mode = nm;
      m_brake = brake;
    end
  endtask
  function automatic logic [9:0] exp_vec();
    int k;
    logic [2:0] sig, bk, ph;
    k   = (m_t / TD) % (L + 1);
    sig = 3'((1 << k) - 1);
    bk  = m_brake ? 3'b111 : 3'b000;
    ph  = ((m_t / TD) % 2 == 0) ? 3'b111 : 3'b000;
    case (m_mode)
      0: return {3'd0, bk, bk, m_brake};
      1: return {3'd1, ph, ph, m_brake};
      2: return m_dir ? {3'd2, sig, bk, m_brake} : {3'd3, bk, sig, m_brake};
      default: return m_dir ? {3'd4, sig, bk, m_brake} : {3'd5, bk, sig, m_brake};
    endcase
  endfunction
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    {hazard, turn_en, turn_dir, brake, lane_req, rst} = '1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if (dut_v !== 10'd0) begin miscompares++; $display("FAIL reset cyc=%0d got=%b exp=%b", i, dut_v, 10'd0); end
    end
    rst = 0;
    cyc();
    vectors++;
    if ({mode_code, led_left, led_right} !== 9'b001_111_111) begin miscompares++; $display("FAIL reset_release got=%b exp=%b", {mode_code, led_left, led_right}, 9'b001_111_111); end
    vectors++;
    if (dut_v !== exp_vec()) begin miscompares++; $display("FAIL reset_release_model got=%b exp=%b", dut_v, exp_vec()); end
  endtask
  task automatic test_right_turn();
    logic [2:0] seq [5] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
    {hazard, brake, lane_req} = '0;
    turn_en = 1; turn_dir = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      vectors++;
      if ({mode_code, led_left, led_right} !== {3'd3, 3'b000, seq[i/4]}) begin miscompares++; $display("FAIL right_turn cyc=%0d got=%b exp=%b", i, {mode_code, led_left, led_right}, {3'd3, 3'b000, seq[i/4]}); end
    end
    brake = 1;
    for (int i = 20; i < 28; i++) begin
      cyc();
      vectors++;
      if (led_left !== 3'b111 || dut_v !== exp_vec()) begin miscompares++; $display("FAIL right_turn_brake cyc=%0d got=%b exp=%b", i, dut_v, exp_vec()); end
    end
  endtask
  task automatic test_hazard();
    logic [2:0] e;
    hazard = 1;
    for (int i = 0; i < 16; i++) begin
      brake = 1'($urandom);
      cyc();
      e = ((i / 4) % 2 == 0) ? 3'b111 : 3'b000;
      vectors++;
      if ({mode_code, led_left, led_right} !== {3'd1, e, e}) begin miscompares++; $display("FAIL hazard cyc=%0d got=%b exp=%b", i, {mode_code, led_left, led_right}, {3'd1, e, e}); end
    end
  endtask
  task automatic test_lane();
    logic [2:0] e;
    {hazard, turn_en, brake, lane_req} = '0;
    cyc();
    vectors++;
    if (dut_v !== exp_vec()) begin miscompares++; $display("FAIL lane_idle got=%b exp=%b", dut_v, exp_vec()); end
    turn_dir = 1; lane_req = 1;
    for (int i = 0; i <= 32; i++) begin
      if (i == 10) begin lane_req = 1; turn_dir = 1'($urandom); end
      cyc();
      lane_req = 0;
      e = 3'((1 << ((i / 4) % 4)) - 1);
      vectors++;
      if (i < 32 && {mode_code, led_left, led_right} !== {3'd4, e, 3'b000}) begin miscompares++; $display("FAIL lane cyc=%0d got=%b exp=%b", i, {mode_code, led_left, led_right}, {3'd4, e, 3'b000}); end
      if (i == 32 && {mode_code, led_left, led_right} !== 9'd0) begin miscompares++; $display("FAIL lane_end got=%b exp=%b", {mode_code, led_left, led_right}, 9'd0); end
      vectors++;
      if (dut_v !== exp_vec()) begin miscompares++; $display("FAIL lane_model cyc=%0d got=%b exp=%b", i, dut_v, exp_vec()); end
    end
  endtask
  task automatic test_preempt();
    turn_dir = 1'($urandom); lane_req = 1;
    for (int i = 0; i <= 8; i++) begin cyc(); lane_req = 0; end
    vectors++;
    if (dut_v !== exp_vec()) begin miscompares++; $display("FAIL preempt_lane got=%b exp=%b", dut_v, exp_vec()); end
    hazard = 1;
    cyc();
    vectors++;
    if ({mode_code, led_left, led_right} !== 9'b001_111_111) begin miscompares++; $display("FAIL preempt_haz got=%b exp=%b", {mode_code, led_left, led_right}, 9'b001_111_111); end
    hazard = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      vectors++;
      if ({mode_code, led_left, led_right} !== 9'd0) begin miscompares++; $display("FAIL preempt_idle cyc=%0d got=%b exp=%b", i, {mode_code, led_left, led_right}, 9'd0); end
    end
  endtask
  task automatic test_reset_mid_turn();
    turn_en = 1; turn_dir = 1'($urandom);
    for (int i = 0; i <= 8; i++) cyc();
    vectors++;
    if ((turn_dir ? led_left : led_right) !== 3'b011) begin miscompares++; $display("FAIL mid_turn_step2 got=%b exp=%b", turn_dir ? led_left : led_right, 3'b011); end
    rst = 1;
    cyc();
    vectors++;
    if (dut_v !== 10'd0) begin miscompares++; $display("FAIL mid_turn_reset got=%b exp=%b", dut_v, 10'd0); end
    rst = 0;
    cyc();
    vectors++;
    if ({mode_code, led_left, led_right} !== {turn_dir ? 3'd2 : 3'd3, 6'd0}) begin miscompares++; $display("FAIL mid_turn_restart got=%b exp=%b", {mode_code, led_left, led_right}, {turn_dir ? 3'd2 : 3'd3, 6'd0}); end
    for (int i = 0; i < 4; i++) cyc();
    vectors++;
    if ((turn_dir ? led_left : led_right) !== 3'b001) begin miscompares++; $display("FAIL mid_turn_step1 got=%b exp=%b", turn_dir ? led_left : led_right, 3'b001); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 29) == 0) hazard = ~hazard;
      if ($urandom_range(0, 24) == 0) turn_en = ~turn_en;
      if ($urandom_range(0, 14) == 0) turn_dir = ~turn_dir;
      if ($urandom_range(0, 9) == 0) brake = ~brake;
      lane_req = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 399) == 0;
      cyc();
      vectors++;
      if (dut_v !== exp_vec()) begin miscompares++; $display("FAIL random cyc=%0d got=%b exp=%b", n, dut_v, exp_vec()); end
    end
    rst = 0; lane_req = 0;
  endtask
  initial begin
    test_reset();
    test_right_turn();
    test_hazard();
    test_lane();
    test_preempt();
    test_reset_mid_turn();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tail_light_seq.md
Name: tail_light_seq

Overview:
- Parametrised successor to the Project 3 tail-light controller.
- Drives two lamp banks (left/right) of LAMPS lamps each, with: sequential-fill turn signals, hazard flash, brake solid-on, brake overlay during turns, and a new auto-cancelling lane-change mode (LC_CYCLES sweeps, then self-cancel).
- Sits under the board top, between switch/key conditioning and LEDR/HEX0 drivers.

Parameters:
- LAMPS, 3, lamps per side (1..8).
- TICK_DIV, 5000000, ADC_CLK_10 cycles per animation tick (0.5 s at 10 MHz); must be >= 2.
- LC_CYCLES, 3, full fill sweeps performed by one lane-change request (1..15).

Ports:
- ADC_CLK_10  in  1  system clock, 10 MHz.
- RST  in  1  synchronous, active-high reset.
- hazard  in  1  level: hazard request.
- turn_en  in  1  level: turn signal active.
- turn_dir  in  1  1 = left, 0 = right; used by turn and lane change.
- brake  in  1  level: brake pedal.
- lane_req  in  1  single-cycle pulse: start lane change toward turn_dir.
- led_left  out  LAMPS  bit 0 = innermost lamp.
- led_right  out  LAMPS  bit 0 = innermost lamp.
- mode_code  out  3  0 idle, 1 hazard, 2 turn-left, 3 turn-right, 4 lane-left, 5 lane-right.
- brake_active  out  1  registered copy of brake.

Behaviour:
- All state and outputs update on the rising edge of ADC_CLK_10.
- Outputs are Moore-decoded from registers: an input sampled at edge k is reflected just after edge k.
- RST=1 at any edge, including mid-sequence: state IDLE, step=0, prescaler=0, lc_count=0, brake_q=0. All outputs 0 on the following cycle.
- Prescaler counts 0..TICK_DIV-1. tick=1 when count==TICK_DIV-1, then wraps to 0. Prescaler and step clear to 0 on every state change.
- States: IDLE, HAZ, TURN, LANE. Priority each cycle: RST > hazard > turn_en > lane in progress / lane_req > IDLE.
- IDLE -> HAZ when hazard=1. IDLE -> TURN when turn_en=1. IDLE -> LANE on lane_req=1; latch lane_dir=turn_dir, lc_count=0.
- HAZ:
  - Phase bit starts 1, so both banks are all-ones on entry.
  - Phase toggles on each tick.
  - Brake is ignored.
  - hazard=0 -> re-evaluate priority: TURN if turn_en, else IDLE.
- TURN:
  - Direction follows live turn_dir.
  - A turn_dir change restarts the sequence at step 0.
  - Step 0..LAMPS; pattern = (1<<step)-1, so 000,001,011,111 for LAMPS=3.
  - At step==LAMPS, a tick wraps step to 0.
  - turn_en=0 -> IDLE.
- LANE:
  - Same fill pattern, using latched lane_dir.
  - lc_count increments on the step LAMPS -> 0 wrap.
  - When lc_count reaches LC_CYCLES, go to IDLE.
  - lane_req while in LANE is ignored; no extension.
  - hazard or turn_en preempts LANE; lane state is discarded.
- Brake overlay, using registered brake_q:
  - IDLE: both banks all-ones.
  - TURN/LANE: the non-signalling bank is all-ones; the signalling bank animates unaffected.
  - HAZ: no effect.
- Simultaneous hazard and turn_en rising: HAZ wins. turn_en is honoured when hazard drops.
- lane_req together with turn_en=1: TURN wins and the lane request is dropped.

Decomposition:
- Shared package tail_light_pkg:
  - state enum (IDLE, HAZ, TURN, LANE);
  - mode_code constants MODE_IDLE..MODE_LANE_R;
  - fill_pattern function: step -> LAMPS-wide thermometer code.
- Sub-module tick_prescaler (parameter TICK_DIV; inputs ADC_CLK_10, RST, clr; output tick). It is reused by the HEX0 blink logic.

Test Plan:
Bench parameters: TICK_DIV=4, LAMPS=3, LC_CYCLES=2.
1. Reset: hold RST=1 for 3 cycles with all inputs 1 -> led_left=led_right=000 and mode_code=0. Release -> next cycle led_left=led_right=111 and mode_code=1.
2. Right turn: turn_en=1, turn_dir=0 -> led_right sequence 000,001,011,111,000 with each value held 4 cycles; led_left=000; mode_code=3. Add brake=1 -> led_left=111 the cycle after brake is sampled; led_right keeps animating.
3. Hazard: hazard=1 -> both banks 111 for 4 cycles, then 000 for 4 cycles, repeating; mode_code=1. brake=1 causes no change.
4. Lane change: pulse lane_req for 1 cycle with turn_dir=1 -> led_left runs 000..111 twice (32 cycles total). Then mode_code=0 and both banks 000. A second lane_req mid-sequence does not extend it.
5. Preemption: hazard=1 during LANE step 2 -> next cycle HAZ with both banks 111. Drop hazard -> IDLE, and the lane sequence does not resume.
6. Reset mid-turn at step 2: RST=1 for 1 cycle -> outputs 000. With turn_en still 1, the turn restarts at step 0 the cycle after RST drops.
